// File: rtl/mvdm_pkg.sv
// Shared types and constants for the motion-vector pixel SRAM scheduler.
// Address field widths, pixel/word sizes, requester ids and FSM states.
package mvdm_pkg;

  localparam int IMG_W       = 1;
  localparam int ROW_W       = 7;
  localparam int WORD_W      = 3;
  localparam int LANE_W      = 4;
  localparam int ADDR_W      = IMG_W + ROW_W + WORD_W;
  localparam int CNT_W       = ADDR_W + LANE_W;
  localparam int PIX_W       = 8;
  localparam int WORD_BITS   = 128;
  localparam int LANES       = WORD_BITS / PIX_W;
  localparam int NUM_PIX_DEF = 32768;

  typedef enum logic {
    REQ_L0 = 1'b0,
    REQ_L1 = 1'b1
  } req_id_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } st_e;

endpackage

// File: rtl/mvdm_rr_arb2.sv
// Two-way round-robin read arbiter; wr_blk suppresses all grants.
// Ports: clk, rst_n, req[1:0] in; wr_blk in; gnt[1:0] one-hot out (comb).
module mvdm_rr_arb2
  import mvdm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       wr_blk,
  output logic [1:0] gnt
);

  req_id_e last_gnt_q, last_gnt_d;

  always_comb begin
    gnt        = 2'b00;
    last_gnt_d = last_gnt_q;
    if (!wr_blk) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_gnt_q == REQ_L1) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    if (gnt[1])      last_gnt_d = REQ_L1;
    else if (gnt[0]) last_gnt_d = REQ_L0;
  end

  // Reset to L1 so that L0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_gnt_q <= REQ_L1;
    else        last_gnt_q <= last_gnt_d;
  end

endmodule

// File: rtl/mvdm_sram_sched.sv
// Pixel SRAM scheduler: packs the 8-bit load stream into 128-bit writes and
// arbitrates L0/L1 word reads. Writes win the port; reads get tagged replies.
// Ports: pix_valid/pix_data in, load_done out; rd_req/rd_addr0/rd_addr1 in,
// rd_gnt out; rsp_valid/rsp_id/rsp_data out; sram_a/sram_di/sram_web out,
// sram_do in. Option macro MVDM_SRAM_RSP_REG_EN registers rsp_data (T+2).
module mvdm_sram_sched
  import mvdm_pkg::*;
#(
  parameter int NUM_PIX = NUM_PIX_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_valid,
  input  logic [PIX_W-1:0]     pix_data,
  output logic                 load_done,
  input  logic [1:0]           rd_req,
  input  logic [ADDR_W-1:0]    rd_addr0,
  input  logic [ADDR_W-1:0]    rd_addr1,
  output logic [1:0]           rd_gnt,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic [WORD_BITS-1:0] rsp_data,
  output logic [ADDR_W-1:0]    sram_a,
  output logic [WORD_BITS-1:0] sram_di,
  output logic                 sram_web,
  input  logic [WORD_BITS-1:0] sram_do
);

  st_e                  st_q, st_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PIX_W-1:0]     buf_q [LANES-1];
  logic [PIX_W-1:0]     buf_d [LANES-1];
  logic                 done_q, done_d;
  logic [ADDR_W-1:0]    sram_a_q, sram_a_d;
  logic [WORD_BITS-1:0] sram_di_q, sram_di_d;
  logic                 rsp_valid_q, rsp_valid_d;
  req_id_e              rsp_id_q, rsp_id_d;

  logic [LANE_W-1:0]    lane;
  logic                 last_pix;
  logic                 wr_en;
  logic [WORD_BITS-1:0] wr_word;

  assign lane     = cnt_q[LANE_W-1:0];
  assign last_pix = (cnt_q == CNT_W'(NUM_PIX - 1));
  assign wr_en    = pix_valid && (lane == LANE_W'(LANES - 1));

  mvdm_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (rd_req),
    .wr_blk (wr_en),
    .gnt    (rd_gnt)
  );

  // Word being written: the live pixel fills the top lane.
  always_comb begin
    wr_word = '0;
    for (int i = 0; i < LANES - 1; i++) begin
      wr_word[i*PIX_W +: PIX_W] = buf_q[i];
    end
    wr_word[WORD_BITS-1 -: PIX_W] = pix_data;
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    buf_d  = buf_q;
    done_d = 1'b0;
    if (pix_valid) begin
      cnt_d  = last_pix ? '0 : cnt_q + 1'b1;
      done_d = last_pix;
      if (!wr_en) buf_d[lane] = pix_data;
    end
    unique case (st_q)
      ST_IDLE: if (pix_valid && !last_pix) st_d = ST_LOAD;
      ST_LOAD: if (pix_valid && last_pix)  st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  // Port mux: write, else granted read, else hold the last address.
  always_comb begin
    sram_web = 1'b1;
    sram_a   = sram_a_q;
    sram_di  = sram_di_q;
    unique case (1'b1)
      wr_en: begin
        sram_web = 1'b0;
        sram_a   = cnt_q[CNT_W-1:LANE_W];
        sram_di  = wr_word;
      end
      rd_gnt[0]: sram_a = rd_addr0;
      rd_gnt[1]: sram_a = rd_addr1;
      default: ;
    endcase
    sram_a_d    = sram_a;
    sram_di_d   = sram_di;
    rsp_valid_d = |rd_gnt;
    rsp_id_d    = rd_gnt[1] ? REQ_L1 : REQ_L0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= ST_IDLE;
      cnt_q       <= '0;
      for (int i = 0; i < LANES - 1; i++) buf_q[i] <= '0;
      done_q      <= 1'b0;
      sram_a_q    <= '0;
      sram_di_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= REQ_L0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      done_q      <= done_d;
      sram_a_q    <= sram_a_d;
      sram_di_q   <= sram_di_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign load_done = done_q;

`ifdef MVDM_SRAM_RSP_REG_EN
  logic                 rsp_v2_q;
  req_id_e              rsp_id2_q;
  logic [WORD_BITS-1:0] rsp_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_v2_q   <= 1'b0;
      rsp_id2_q  <= REQ_L0;
      rsp_data_q <= '0;
    end else begin
      rsp_v2_q   <= rsp_valid_q;
      rsp_id2_q  <= rsp_id_q;
      rsp_data_q <= sram_do;
    end
  end

  assign rsp_valid = rsp_v2_q;
  assign rsp_id    = rsp_id2_q;
  assign rsp_data  = rsp_data_q;
`else
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = sram_do;
`endif

endmodule

// File: doc/mvdm_sram_sched.md
# mvdm_sram_sched

Access scheduler for the 2048 × 128-bit pixel SRAM, 16 pixels per word, used by the motion-vector SAD datapath. It packs the serial 8-bit image-load stream into 16-pixel words and writes them. It also arbitrates word reads from two fetch requesters (L0 and L1 reference blocks) onto the single SRAM port. Writes always win the port; reads use round-robin arbitration and return tagged responses.

## Interface
Parameters:
- `NUM_PIX`, 32768: pixels per full load (2 images × 128 × 128).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous active-low reset.
- `pix_valid` in 1: one load pixel this cycle.
- `pix_data` in 8: pixel value (low 8 bits of `in_data`).
- `load_done` out 1: one-cycle pulse after the last pixel of a load has been written.
- `rd_req` in 2: read request, bit 0 = L0, bit 1 = L1.
- `rd_addr0`, `rd_addr1` in 11: word address {img, row[6:0], word[2:0]}.
- `rd_gnt` out 2: one-hot grant, combinational, same cycle as the request.
- `rsp_valid` out 1: read data valid.
- `rsp_id` out 1: requester of the returned word.
- `rsp_data` out 128: returned word; lane k is at bits [8k+7:8k].
- `sram_a` out 11: SRAM address (A10 = img).
- `sram_di` out 128: SRAM write data.
- `sram_web` out 1: 0 = write, 1 = read.
- `sram_do` in 128: SRAM read data, valid the cycle after its address.

## Operation
- FSM states are ST_IDLE and ST_LOAD.
  - ST_IDLE → ST_LOAD on `pix_valid`.
  - ST_LOAD → ST_IDLE on the cycle the pixel with `pix_cnt == NUM_PIX-1` is accepted.
- `pix_cnt` is 15 bits, increments per accepted pixel and wraps to 0 at the end of a load. It maps to the address as:
  - lane = cnt[3:0]
  - word = cnt[6:4]
  - row = cnt[13:7]
  - img = cnt[14]
- Gaps in `pix_valid` are legal; the count and pack buffer hold during gaps.
- Pack buffer holds 15 × 8-bit lanes; the lane is written on `pix_valid`.
- On `pix_valid` with lane == 15:
  - the write is issued in the same cycle;
  - `sram_web` = 0;
  - `sram_a` = cnt[14:4];
  - `sram_di` = {pix_data, buf[14..0]}.
- Write cycle: `rd_gnt` = 00 and pending requests hold. Reads are blocked at most 1 cycle in 16.
- Read arbitration (no write this cycle):
  - a single request is granted;
  - when both request, the requester not granted last is granted;
  - `last_gnt` resets to 1, so L0 wins the first tie.
- Grant drives `sram_a` from the granted address with `sram_web` = 1. The requester drops or changes its request after seeing the grant.
- No write and no grant: `sram_web` = 1, `sram_a` holds its previous value.
- `rsp_id` and `rsp_valid` are registered from the grant; `rsp_data` = `sram_do`.
- Reads during ST_LOAD to a word already written return the new data. Reads of unwritten words return undefined data; no check is made.

## Timing
- Reset values:
  - state = ST_IDLE, `pix_cnt` = 0, `last_gnt` = 1
  - `load_done` = 0, `rsp_valid` = 0, `rsp_id` = 0
  - `sram_web` = 1, `sram_a` = 0, `sram_di` = 0
- Write latency: 0 cycles from the 16th pixel of a word.
- `load_done` rises the cycle after the final pixel and stays high 1 cycle.
- Read latency:
  - grant at T;
  - `rsp_valid`/`rsp_id` at T+1;
  - `rsp_data` valid at T+1.
- Back-to-back grants give one response per cycle.
- Reset mid-load:
  - the partial word is discarded;
  - the count returns to 0;
  - outstanding responses are dropped (`rsp_valid` = 0).
- A request arriving on a write cycle is granted on the next non-write cycle.

## Configuration
- `MVDM_SRAM_RSP_REG_EN` defined: `rsp_data` is registered from `sram_do`. `rsp_valid`/`rsp_id` are delayed one extra stage, so read latency is T+2. Throughput is unchanged.
- Not defined: the T+1 combinational data path described above.

## Structure
- Shared package `mvdm_pkg` holds:
  - address field widths (IMG_W = 1, ROW_W = 7, WORD_W = 3, LANE_W = 4);
  - `PIX_W` = 8 and `WORD_BITS` = 128;
  - the `NUM_PIX` default;
  - the requester id enum (REQ_L0 = 0, REQ_L1 = 1).
- One sub-module, `mvdm_rr_arb2`: a 2-way round-robin arbiter with a write-block input and a `last_gnt` register.

## Test plan
- Full load, pixels 0..32767 with value = idx[7:0], no gaps:
  - 2048 writes, each with `sram_web` = 0;
  - word 0 `sram_di` = 0x0F0E…0100 at `sram_a` = 0;
  - last write at `sram_a` = 0x7FF;
  - `load_done` pulses exactly once.
- Load with random `pix_valid` gaps: write addresses and data match the gapless run.
- Both requesters hold `rd_req` = 11 for 6 cycles at addresses 0x010 and 0x410:
  - grants alternate L0, L1, L0, …;
  - `rsp_id` follows one cycle later;
  - `rsp_data` equals the stored words.
- `rd_req0` held during a load while the 16th pixel of a word arrives:
  - that cycle `rd_gnt` = 00 and `sram_web` = 0;
  - L0 is granted the next cycle.
- `rst_n` pulsed after 100 pixels, then a full load:
  - the first write goes to `sram_a` = 0 with the post-reset pixels;
  - `load_done` does not pulse for the aborted load.
- With `MVDM_SRAM_RSP_REG_EN`: a single L1 grant at T gives `rsp_valid` = 1 and `rsp_id` = 1 at T+2 with the correct data.
